// File: rtl/psc_pkg.sv
// Shared types and helpers for the partial-sum collector: FSM states and a
// bounded trailing-ones count that sets the merge depth after each accepted bit.
package psc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MERGE = 2'd1,
      FULL  = 2'd2
   } psc_state_e;

   function automatic int trailing_ones(input logic [31:0] x, input int max_cnt);
      int cnt;
      cnt = 0;
      for (int b = 0; b < 32; b++) begin
         if (cnt == b && b < max_cnt && x[b]) begin
            cnt = b + 1;
         end
      end
      return cnt;
   endfunction

endpackage

// File: rtl/ps_window_select.sv
// Registered P-lane window over the partial-sum vector, starting at the lowest set
// bit of the select; lanes past the top of the vector read 0. One-cycle latency, no backpressure.
module ps_window_select #(
   parameter int N = 8,
   parameter int P = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] i_v,
   input  logic [N-1:0] i_dv,
   output logic [P-1:0] o_ps
);

   logic [N+P-1:0] w_vx;
   logic [P-1:0]   w_sel;
   logic [P-1:0]   r_ps;

   // Zero padding above the vector supplies the out-of-range lanes.
   assign w_vx = {{P{1'b0}}, i_v};

   always_comb begin
      w_sel = '0;
      for (int d = N - 1; d >= 0; d--) begin
         if (i_dv[d]) begin
            w_sel = w_vx[d +: P];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ps <= '0;
      end else begin
         r_ps <= w_sel;
      end
   end

   assign o_ps = r_ps;

endmodule

// File: rtl/partial_sums_collector.sv
// In-place polar partial-sum collector: one decoded bit per IDLE cycle, then one merge level per cycle
// (ready low while merging/full). Define PSC_ERR_EN for a sticky err on psn_en while not ready.
module partial_sums_collector
   import psc_pkg::*;
#(
   parameter int n = 3,
   parameter int p = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            psn_rst,
   input  logic            psn_en,
   input  logic            u_hat,
   input  logic [2**n-1:0] distribute_vector,
   output logic [2**p-1:0] ps_out,
   output logic            ready,
   output logic [n:0]      bit_count,
   output logic            block_done,
   output logic            err
);

   localparam int N  = 2**n;
   localparam int P  = 2**p;
   localparam int LW = $clog2(n + 1);
   localparam logic [n:0] N_CNT = (n+1)'(N);

   psc_state_e      r_state;
   psc_state_e      w_state_next;
   logic [N-1:0]    r_v;
   logic [N-1:0]    w_v_merged;
   logic [2*N-1:0]  w_vx;
   logic [n:0]      r_bit_count;
   logic [n-1:0]    r_idx;
   logic [n-1:0]    w_i;
   logic [LW-1:0]   r_level;
   logic [LW-1:0]   r_depth;
   logic [LW-1:0]   w_depth;
   logic            w_accept;
   logic            w_merge;
   logic            w_last;
   logic            w_done_next;
   logic            r_block_done;

   assign w_i     = r_bit_count[n-1:0];
   assign w_depth = LW'(trailing_ones(32'(w_i), n));
   assign w_last  = (r_level == r_depth);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_accept     = 1'b0;
      w_merge      = 1'b0;
      w_done_next  = 1'b0;
      case (r_state)
         IDLE: begin
            if (psn_en) begin
               w_accept = 1'b1;
               if (w_depth != '0) begin
                  w_state_next = MERGE;
               end
            end
         end
         MERGE: begin
            w_merge = 1'b1;
            if (w_last) begin
               if (r_bit_count == N_CNT) begin
                  w_state_next = FULL;
                  w_done_next  = 1'b1;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         FULL: begin
            w_state_next = FULL;
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
      if (psn_rst) begin
         w_state_next = IDLE;
         w_accept     = 1'b0;
         w_merge      = 1'b0;
         w_done_next  = 1'b0;
      end
   end

   // Level k folds the upper half of the 2^k-wide block ending at r_idx into its lower half.
   assign w_vx = {{N{1'b0}}, r_v};

   always_comb begin
      w_v_merged = r_v;
      for (int k = 1; k <= n; k++) begin
         for (int j = 0; j < N; j++) begin
            if (int'(r_level) == k &&
                j >= int'(r_idx) + 1 - (1 << k) &&
                j <  int'(r_idx) + 1 - (1 << k) + (1 << (k - 1))) begin
               w_v_merged[j] = r_v[j] ^ w_vx[j + (1 << (k - 1))];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v          <= '0;
         r_bit_count  <= '0;
         r_idx        <= '0;
         r_level      <= '0;
         r_depth      <= '0;
         r_block_done <= 1'b0;
      end else begin
         r_block_done <= w_done_next;
         if (psn_rst) begin
            r_v         <= '0;
            r_bit_count <= '0;
            r_level     <= '0;
         end else if (w_accept) begin
            r_v[w_i]    <= u_hat;
            r_bit_count <= r_bit_count + (n+1)'(1);
            r_idx       <= w_i;
            r_depth     <= w_depth;
            r_level     <= LW'(1);
         end else if (w_merge) begin
            r_v     <= w_v_merged;
            r_level <= r_level + LW'(1);
         end
      end
   end

`ifdef PSC_ERR_EN
   logic r_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (psn_rst) begin
         r_err <= 1'b0;
      end else if (psn_en && r_state != IDLE) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   ps_window_select #(
      .N (N),
      .P (P)
   ) u_window (
      .clk  (clk),
      .rst  (rst),
      .i_v  (r_v),
      .i_dv (distribute_vector),
      .o_ps (ps_out)
   );

   assign ready      = (r_state == IDLE);
   assign bit_count  = r_bit_count;
   assign block_done = r_block_done;

endmodule

// File: tb/tb_partial_sums_collector.sv
// Randomized bench for partial_sums_collector (n=3, p=1) against an array-based model of the merge rules.
module tb_partial_sums_collector;

   logic       clk = 1'b0;
   logic       rst;
   logic       psn_rst;
   logic       psn_en;
   logic       u_hat;
   logic [7:0] dv;
   logic [1:0] ps_out;
   logic       ready;
   logic [3:0] bit_count;
   logic       block_done;
   logic       err;

   int checks = 0;
   int errors = 0;

   bit mv [8];
   int mcount;
   bit exp_err;

   always #5 clk = ~clk;

   partial_sums_collector #(.n(3), .p(1)) dut (
      .clk               (clk),
      .rst               (rst),
      .psn_rst           (psn_rst),
      .psn_en            (psn_en),
      .u_hat             (u_hat),
      .distribute_vector (dv),
      .ps_out            (ps_out),
      .ready             (ready),
      .bit_count         (bit_count),
      .block_done        (block_done),
      .err               (err)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int tones(input int i);
      int c;
      c = 0;
      while (c < 3 && ((i >> c) & 1) == 1) c++;
      return c;
   endfunction

   task automatic model_clear;
      for (int k = 0; k < 8; k++) mv[k] = 1'b0;
      mcount = 0;
   endtask

   task automatic model_accept(input bit u, output int depth);
      int i;
      int b;
      int h;
      i = mcount;
      mv[i] = u;
      mcount++;
      depth = tones(i);
      for (int k = 1; k <= depth; k++) begin
         h = 1 << (k - 1);
         b = i + 1 - (1 << k);
         for (int j = b; j < b + h; j++) mv[j] = mv[j] ^ mv[j + h];
      end
   endtask

   task automatic clear_frame;
      psn_rst = 1'b1;
      tick;
      psn_rst = 1'b0;
      model_clear();
   endtask

   task automatic check_window(input logic [7:0] d, input string name);
      logic [1:0] exp;
      int lo;
      exp = 2'b00;
      lo = -1;
      for (int k = 0; k < 8; k++) if (d[k] && lo < 0) lo = k;
      if (lo >= 0) begin
         for (int m = 0; m < 2; m++) if (lo + m < 8) exp[m] = mv[lo + m];
      end
      dv = d;
      tick;
      checks++;
      if (ps_out !== exp) begin
         errors++;
         $display("FAIL %s dv=%h ps_out=%b expected=%b", name, d, ps_out, exp);
      end
   endtask

   task automatic sweep(input string name);
      for (int d = 0; d < 8; d++) check_window(8'(1 << d), name);
   endtask

   task automatic wait_ready(input string name);
      int guard;
      guard = 0;
      while (!ready && guard < 50) begin
         tick;
         guard++;
      end
      checks++;
      if (!ready) begin
         errors++;
         $display("FAIL %s_ready_timeout ready=%b expected=1", name, ready);
      end
   endtask

   task automatic send_bit(input bit u, input string name);
      int depth;
      int lowcnt;
      wait_ready(name);
      psn_en = 1'b1;
      u_hat  = u;
      tick;
      psn_en = 1'b0;
      model_accept(u, depth);
      lowcnt = 0;
      while (!ready && !block_done && lowcnt < 20) begin
         lowcnt++;
         tick;
      end
      checks++;
      if (lowcnt != depth) begin
         errors++;
         $display("FAIL %s_busy_cycles got=%0d expected=%0d", name, lowcnt, depth);
      end
      checks++;
      if (bit_count !== 4'(mcount)) begin
         errors++;
         $display("FAIL %s_bit_count got=%0d expected=%0d", name, bit_count, mcount);
      end
      checks++;
      if (block_done !== (mcount == 8)) begin
         errors++;
         $display("FAIL %s_block_done got=%b expected=%b", name, block_done, (mcount == 8));
      end
      if (mcount == 8) begin
         tick;
         checks++;
         if (block_done !== 1'b0 || ready !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse block_done=%b ready=%b expected 0/0", name, block_done, ready);
         end
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; psn_rst = 1'b0; psn_en = 1'b0; u_hat = 1'b0; dv = 8'hFF;
      #2;
      checks++;
      if (ps_out !== 2'b00 || ready !== 1'b1 || bit_count !== 4'd0 || err !== 1'b0 || block_done !== 1'b0) begin
         errors++;
         $display("FAIL reset ps_out=%b ready=%b bit_count=%0d err=%b block_done=%b expected 00/1/0/0/0",
                  ps_out, ready, bit_count, err, block_done);
      end
      @(negedge clk);
      rst = 1'b0;
      dv = 8'h00;
      model_clear();
      tick;
   endtask

   task automatic test_two_bit_merge;
      clear_frame();
      send_bit(1'b1, "two_bit_i0");
      send_bit(1'b1, "two_bit_i1");
      check_window(8'h01, "two_bit_window");
      checks++;
      if (ps_out !== 2'b10) begin
         errors++;
         $display("FAIL two_bit_literal ps_out=%b expected=10", ps_out);
      end
   endtask

   task automatic test_full_frame;
      clear_frame();
      for (int i = 0; i < 8; i++) send_bit(1'b1, "full_frame");
      check_window(8'h40, "full_win40");
      checks++;
      if (ps_out !== 2'b10) begin
         errors++;
         $display("FAIL full_win40_literal ps_out=%b expected=10", ps_out);
      end
      check_window(8'h80, "full_win80");
      checks++;
      if (ps_out !== 2'b01) begin
         errors++;
         $display("FAIL full_win80_literal ps_out=%b expected=01", ps_out);
      end
      check_window(8'h00, "full_win_zero");
      sweep("full_sweep");
      psn_en = 1'b1; u_hat = 1'b0;
      tick;
      psn_en = 1'b0;
      tick;
`ifdef PSC_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      checks++;
      if (bit_count !== 4'd8 || ready !== 1'b0 || err !== exp_err) begin
         errors++;
         $display("FAIL full_ignore_en bit_count=%0d ready=%b err=%b expected 8/0/%b", bit_count, ready, err, exp_err);
      end
      sweep("full_after_en");
      clear_frame();
      checks++;
      if (err !== 1'b0 || ready !== 1'b1 || bit_count !== 4'd0) begin
         errors++;
         $display("FAIL full_clear err=%b ready=%b bit_count=%0d expected 0/1/0", err, ready, bit_count);
      end
   endtask

   task automatic test_random_frames;
      for (int f = 0; f < 4; f++) begin
         clear_frame();
         for (int i = 0; i < 8; i++) send_bit(1'($urandom_range(0, 1)), "rand_frame");
         sweep("rand_sweep");
         for (int r = 0; r < 4; r++) check_window(8'($urandom), "rand_window");
      end
      clear_frame();
      for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)), "rand_partial");
      sweep("rand_partial_sweep");
   endtask

   task automatic test_mid_merge_clear;
      clear_frame();
      for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), "mid_fill");
      wait_ready("mid_last");
      psn_en = 1'b1; u_hat = 1'b1;
      tick;
      psn_en = 1'b0;
      checks++;
      if (ready !== 1'b0) begin
         errors++;
         $display("FAIL mid_in_merge ready=%b expected=0", ready);
      end
      psn_rst = 1'b1;
      tick;
      psn_rst = 1'b0;
      model_clear();
      checks++;
      if (ready !== 1'b1 || bit_count !== 4'd0 || block_done !== 1'b0) begin
         errors++;
         $display("FAIL mid_clear ready=%b bit_count=%0d block_done=%b expected 1/0/0", ready, bit_count, block_done);
      end
      for (int c = 0; c < 5; c++) begin
         tick;
         checks++;
         if (block_done !== 1'b0 || ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_no_done block_done=%b ready=%b expected 0/1", block_done, ready);
         end
      end
      sweep("mid_zero_sweep");
   endtask

   task automatic test_err;
      int depth;
      clear_frame();
      for (int i = 0; i < 3; i++) send_bit(1'($urandom_range(0, 1)), "err_fill");
      wait_ready("err_i3");
      u_hat = 1'($urandom_range(0, 1));
      psn_en = 1'b1;
      tick;
      model_accept(u_hat, depth);
      u_hat = ~u_hat;
      tick;
      psn_en = 1'b0;
      wait_ready("err_after");
`ifdef PSC_ERR_EN
      exp_err = 1'b1;
`else
      exp_err = 1'b0;
`endif
      checks++;
      if (err !== exp_err || bit_count !== 4'd4) begin
         errors++;
         $display("FAIL err_set err=%b bit_count=%0d expected %b/4", err, bit_count, exp_err);
      end
      sweep("err_v_intact");
      send_bit(1'b1, "err_next");
      checks++;
      if (err !== exp_err) begin
         errors++;
         $display("FAIL err_sticky err=%b expected=%b", err, exp_err);
      end
      clear_frame();
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear err=%b expected=0", err);
      end
   endtask

   initial begin
      test_reset();
      test_two_bit_merge();
      test_full_frame();
      test_random_frames();
      test_mid_merge_clear();
      test_err();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
